// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester for 8-bit APB slaves.
//   Takes one read/write command from the CPU-side port, runs the
//   SETUP/ACCESS handshake and returns a one-cycle response. It also keeps a
//   sticky pending flag for the slave's rx_interrupt.
//
// Optional feature (compile-time macro APB_MASTER_TIMEOUT_EN):
//   When defined, an ACCESS phase that sees no pready for TO_CYC cycles is
//   aborted and answered with rsp_err=1. When undefined, ACCESS waits
//   indefinitely and rsp_err is always 0.
//
// Ports:
//   pclk, npreset           clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready     command handshake (accepted when both are high)
//   cmd_write, cmd_wdata    command direction and write data
//   rsp_valid               one-cycle pulse when a transfer completes
//   rsp_rdata, rsp_err      read data (0 on writes), timeout flag
//   psel, penable, pwrite,
//   pwdata                  APB request signals (all registered)
//   prdata, pready          APB response from the slave
//   rx_interrupt            slave receive interrupt (level)
//   irq_pending, irq_clear  sticky interrupt flag and its clear
module apb_master #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TO_CYC = 64
) (
  input  logic              pclk,
  input  logic              npreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              rx_interrupt,
  output logic              irq_pending,
  input  logic              irq_clear
);

  // Reject a timeout length the 8-bit counter cannot represent.
  if (TO_CYC < 2 || TO_CYC > 256) begin : g_bad_to_cyc
    $error("apb_master: TO_CYC must be in the range 2..256");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic              accept_c;
  logic              timeout_c;

  logic              cmd_ready_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_err_d;
  logic              psel_d;
  logic              penable_d;
  logic              pwrite_d;
  logic [DATA_W-1:0] pwdata_d;
  logic              irq_pending_d;

  assign accept_c = (state == S_IDLE) && cmd_valid;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned       CNT_W   = 8;
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TO_CYC - 1);

  logic [CNT_W-1:0] to_cnt;

  // Counts ACCESS cycles without pready; zeroed during SETUP so it starts at 0.
  always_ff @(posedge pclk or negedge npreset) begin
    if (!npreset) begin
      to_cnt <= '0;
    end else if (state == S_SETUP) begin
      to_cnt <= '0;
    end else if ((state == S_ACCESS) && !pready) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  // A pready on the last allowed cycle wins over the abort.
  assign timeout_c = (state == S_ACCESS) && !pready && (to_cnt == TO_LAST);
`else
  assign timeout_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge pclk or negedge npreset) begin
    if (!npreset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (cmd_valid) state_nx = S_SETUP;
      S_SETUP:  state_nx = S_ACCESS;
      S_ACCESS: if (pready || timeout_c) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Output next-values, decoded from the state being entered so every
  // output can be registered without an extra cycle of latency.
  always_comb begin
    cmd_ready_d   = (state_nx == S_IDLE);
    psel_d        = (state_nx == S_SETUP) || (state_nx == S_ACCESS);
    penable_d     = (state_nx == S_ACCESS);
    rsp_valid_d   = (state_nx == S_DONE);
    rsp_err_d     = timeout_c;
    rsp_rdata_d   = '0;
    pwrite_d      = pwrite;
    pwdata_d      = pwdata;
    irq_pending_d = irq_pending;

    if (accept_c) begin
      pwrite_d = cmd_write;
      pwdata_d = cmd_wdata;
    end

    // Read data is only non-zero for the DONE cycle of a completed read.
    if ((state == S_ACCESS) && pready && !pwrite) begin
      rsp_rdata_d = prdata;
    end

    // Set has priority over clear.
    if (rx_interrupt) begin
      irq_pending_d = 1'b1;
    end else if (irq_clear) begin
      irq_pending_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge pclk or negedge npreset) begin
    if (!npreset) begin
      cmd_ready   <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      cmd_ready   <= cmd_ready_d;
      psel        <= psel_d;
      penable     <= penable_d;
      pwrite      <= pwrite_d;
      pwdata      <= pwdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      irq_pending <= irq_pending_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed and randomized transfers checked cycle by
// cycle against expectations derived from transfer timing rules (accept at
// cycle 0, SETUP at 1, ACCESS until pready, DONE one cycle later).
module tb_apb_master;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TO_CYC = 64;

  logic              pclk;
  logic              npreset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              rx_interrupt;
  logic              irq_pending;
  logic              irq_clear;

  int errors = 0;
  int checks = 0;

  apb_master #(.DATA_W(DATA_W), .TO_CYC(TO_CYC)) dut (
    .pclk         (pclk),
    .npreset      (npreset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .pwdata       (pwdata),
    .prdata       (prdata),
    .pready       (pready),
    .rx_interrupt (rx_interrupt),
    .irq_pending  (irq_pending),
    .irq_clear    (irq_clear)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance one cycle; outputs are sampled and inputs changed 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // One transfer. Expected timing relative to the accept cycle (c=0) with
  // pready first seen on ACCESS cycle d+1:
  //   psel c=1..d+2, penable c=2..d+2, rsp_valid c=d+3, cmd_ready again c=d+4.
  task automatic run_txn(input bit wr, input logic [DATA_W-1:0] wd,
                         input logic [DATA_W-1:0] rd, input int d,
                         input bit hold_valid, input string tag);
    logic [3:0]        exp_ctl;
    logic [DATA_W-1:0] exp_rd;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s cmd_ready_before_accept got %b exp 1", tag, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_wdata = wd;
    pready    = 1'($urandom_range(0, 1));
    prdata    = DATA_W'($urandom);
    exp_rd    = wr ? '0 : rd;
    for (int c = 1; c <= d + 4; c++) begin
      step();
      exp_ctl = {(c <= d + 2), (c >= 2 && c <= d + 2), (c == d + 3), (c >= d + 4)};
      checks++;
      if ({psel, penable, rsp_valid, cmd_ready} !== exp_ctl) begin
        errors++;
        $display("FAIL %s ctl c=%0d psel/penable/rsp_valid/cmd_ready got %b exp %b",
                 tag, c, {psel, penable, rsp_valid, cmd_ready}, exp_ctl);
      end
      checks++;
      if ({pwrite, pwdata} !== {wr, wd}) begin
        errors++;
        $display("FAIL %s hold c=%0d pwrite/pwdata got %b/%h exp %b/%h",
                 tag, c, pwrite, pwdata, wr, wd);
      end
      if (c == d + 3) begin
        checks++;
        if ({rsp_err, rsp_rdata} !== {1'b0, exp_rd}) begin
          errors++;
          $display("FAIL %s rsp rsp_err/rsp_rdata got %b/%h exp 0/%h",
                   tag, rsp_err, rsp_rdata, exp_rd);
        end
      end
      if (c < d + 4) begin
        cmd_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
        cmd_write = 1'($urandom_range(0, 1));
        cmd_wdata = DATA_W'($urandom);
        if (c >= 2 && c <= d + 1) pready = 1'b0;
        else if (c == d + 2)      pready = 1'b1;
        else                      pready = 1'($urandom_range(0, 1));
        prdata = (c == d + 2) ? rd : DATA_W'($urandom);
      end
    end
    if (!hold_valid) cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    npreset      = 1'b0;
    cmd_valid    = 1'b0;
    cmd_write    = 1'b0;
    cmd_wdata    = '0;
    prdata       = '0;
    pready       = 1'b0;
    rx_interrupt = 1'b0;
    irq_clear    = 1'b0;
    #1;
    step();
    step();
    checks++;
    if ({psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err, irq_pending} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 0000000",
               {psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err, irq_pending});
    end
    checks++;
    if ({pwdata, rsp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data pwdata/rsp_rdata got %h/%h exp 0/0", pwdata, rsp_rdata);
    end
    npreset = 1'b1;
    step();
    checks++;
    if ({cmd_ready, psel, penable} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release cmd_ready/psel/penable got %b exp 100",
               {cmd_ready, psel, penable});
    end
  endtask

  task automatic test_irq();
    bit model;
    bit rx_seq [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bit cl_seq [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit exp_seq[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      rx_interrupt = rx_seq[i];
      irq_clear    = cl_seq[i];
      step();
      checks++;
      if (irq_pending !== exp_seq[i]) begin
        errors++;
        $display("FAIL irq_directed step=%0d got %b exp %b", i, irq_pending, exp_seq[i]);
      end
    end
    model = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rx_interrupt = ($urandom_range(0, 3) == 0);
      irq_clear    = 1'($urandom_range(0, 1));
      if (rx_interrupt)   model = 1'b1;
      else if (irq_clear) model = 1'b0;
      step();
      checks++;
      if (irq_pending !== model) begin
        errors++;
        $display("FAIL irq_random step=%0d got %b exp %b", i, irq_pending, model);
      end
    end
    rx_interrupt = 1'b0;
    irq_clear    = 1'b1;
    step();
    irq_clear    = 1'b0;
  endtask

  task automatic test_write();
    run_txn(1'b1, 8'hA5, 8'h00, 0, 1'b0, "write_a5");
  endtask

  task automatic test_read_wait();
    run_txn(1'b0, 8'h11, 8'h3C, 5, 1'b0, "read_3c_wait5");
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 8'h5A, 8'h00, 0, 1'b1, "b2b_first");
    run_txn(1'b0, 8'h77, 8'hC3, 0, 1'b0, "b2b_second");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_txn(1'($urandom_range(0, 1)), DATA_W'($urandom), DATA_W'($urandom),
              int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), "random");
    end
    cmd_valid = 1'b0;
    step();
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int seen;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_wdata = 8'h00;
    pready    = 1'b0;
    seen      = -1;
    for (int c = 1; c <= 200 && seen < 0; c++) begin
      step();
      cmd_valid = 1'b0;
      if (rsp_valid === 1'b1) begin
        seen = c;
        checks++;
        if ({rsp_err, rsp_rdata} !== {1'b1, 8'h00}) begin
          errors++;
          $display("FAIL timeout_rsp rsp_err/rsp_rdata got %b/%h exp 1/00", rsp_err, rsp_rdata);
        end
      end
    end
    checks++;
    if (seen != int'(TO_CYC) + 2) begin
      errors++;
      $display("FAIL timeout_latency rsp_valid cycle got %0d exp %0d", seen, TO_CYC + 2);
    end
    step();
    run_txn(1'b0, 8'h00, 8'h5A, int'(TO_CYC) - 1, 1'b0, "pready_last_cycle");
  endtask
`else
  task automatic test_no_timeout();
    run_txn(1'b0, 8'h00, 8'h96, 70, 1'b0, "long_wait_no_timeout");
  endtask
`endif

  task automatic test_reset_mid();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_wdata = 8'hE1;
    pready    = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++;
      $display("FAIL midreset_access psel/penable got %b exp 11", {psel, penable});
    end
    #2;
    npreset = 1'b0;
    #1;
    checks++;
    if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_async psel/penable/rsp_valid/cmd_ready got %b exp 0000",
               {psel, penable, rsp_valid, cmd_ready});
    end
    pready = 1'b1;
    step();
    npreset = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL midreset_after c=%0d psel/penable/rsp_valid/cmd_ready got %b exp 0001",
                 c, {psel, penable, rsp_valid, cmd_ready});
      end
    end
    pready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_irq();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_random();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
